// File: rtl/audioport_pkg.sv
// Shared audioport definitions: command codes, STATUS_REG bit indices, rate codes,
// default divider constants and the command sequencer state encoding.
package audioport_pkg;

  localparam logic [31:0] CMD_NOP    = 32'h0000_0000;
  localparam logic [31:0] CMD_CLR    = 32'h0000_0001;
  localparam logic [31:0] CMD_CFG    = 32'h0000_0002;
  localparam logic [31:0] CMD_START  = 32'h0000_0004;
  localparam logic [31:0] CMD_STOP   = 32'h0000_0008;
  localparam logic [31:0] CMD_LEVEL  = 32'h0000_0010;
  localparam logic [31:0] CMD_IRQACK = 32'h0000_0020;

  localparam int STATUS_PLAY    = 0;
  localparam int STATUS_CLR_ERR = 1;
  localparam int STATUS_CFG_ERR = 2;
  localparam int STATUS_IRQ_ERR = 3;
  localparam int STATUS_CMD_ERR = 4;

  typedef enum logic [1:0] {
    RATE_48000  = 2'b00,
    RATE_96000  = 2'b01,
    RATE_192000 = 2'b10,
    RATE_384000 = 2'b11
  } rate_t;

  localparam int DEFAULT_CMD_WAIT_STATES = 24;
  localparam int DEFAULT_DIV_48000       = 1127;
  localparam int DEFAULT_DIV_96000       = 564;
  localparam int DEFAULT_DIV_192000      = 282;
  localparam int DEFAULT_DIV_384000      = 141;
  localparam int DEFAULT_DIV_WIDTH       = 16;

  typedef enum logic [1:0] {
    STOP      = 2'd0,
    PLAY      = 2'd1,
    WAIT_STOP = 2'd2
  } seq_state_t;

  // NOP counts as known: it is accepted silently rather than flagged.
  function automatic logic cmd_is_known(input logic [31:0] cmd);
    return cmd inside {CMD_NOP, CMD_CLR, CMD_CFG, CMD_START, CMD_STOP, CMD_LEVEL, CMD_IRQACK};
  endfunction

endpackage

// File: rtl/audioport_tick_divider.sv
// Sample-rate tick generator: counts 0..DIV-1 for the selected rate while enabled,
// registered tick on the terminal count; clear (or reset) zeroes the count and drops the tick.
module audioport_tick_divider
  import audioport_pkg::*;
#(
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
  parameter int DIV_48000  = DEFAULT_DIV_48000,
  parameter int DIV_96000  = DEFAULT_DIV_96000,
  parameter int DIV_192000 = DEFAULT_DIV_192000,
  parameter int DIV_384000 = DEFAULT_DIV_384000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  logic  clear,
  input  rate_t rate,
  output logic  tick
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] count_last;

  always_comb begin
    count_last = DIV_WIDTH'(DIV_48000 - 1);
    case (rate)
      RATE_48000:  count_last = DIV_WIDTH'(DIV_48000 - 1);
      RATE_96000:  count_last = DIV_WIDTH'(DIV_96000 - 1);
      RATE_192000: count_last = DIV_WIDTH'(DIV_192000 - 1);
      RATE_384000: count_last = DIV_WIDTH'(DIV_384000 - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      tick  <= (count == count_last);
      count <= (count == count_last) ? '0 : count + 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/audioport_cmd_sequencer.sv
// Audioport command sequencer: decodes CMD_REG writes into registered strobes, STATUS_REG and irq; one-cycle latency.
// No backpressure: commands during the wait-state window are dropped with CMD_ERR. AUDIOPORT_RATE_384K_EN enables rate 2'b11.
module audioport_cmd_sequencer
  import audioport_pkg::*;
#(
  parameter int CMD_WAIT_STATES = DEFAULT_CMD_WAIT_STATES,
  parameter int DIV_48000       = DEFAULT_DIV_48000,
  parameter int DIV_96000       = DEFAULT_DIV_96000,
  parameter int DIV_192000      = DEFAULT_DIV_192000,
  parameter int DIV_384000      = DEFAULT_DIV_384000,
  parameter int DIV_WIDTH       = DEFAULT_DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_in,
  input  logic        cmd_valid_in,
  input  logic [31:0] cfg_in,
  input  logic        req_in,
  output logic        play_out,
  output logic        clr_out,
  output logic        cfg_out,
  output logic        level_out,
  output logic        irq_out,
  output logic        busy_out,
  output logic        tick_out,
  output logic [31:0] status_out
);

  localparam int WAIT_W = $clog2(CMD_WAIT_STATES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CMD_WAIT_STATES - 1);

  seq_state_t state, state_nxt;
  rate_t      rate, rate_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [STATUS_CMD_ERR:STATUS_CLR_ERR] err, err_nxt;
  logic irq, irq_nxt;
  logic clr, clr_nxt, cfg, cfg_nxt, level, level_nxt;
  logic div_clear, irq_ack, stop_cmd, req_play;
  rate_t cfg_rate;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_in[31:2];
  assign cfg_rate = rate_t'(cfg_in[1:0]);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    rate_nxt  = rate;
    err_nxt   = err;
    irq_nxt   = irq;
    clr_nxt   = 1'b0;
    cfg_nxt   = 1'b0;
    level_nxt = 1'b0;
    div_clear = 1'b0;
    irq_ack   = 1'b0;
    stop_cmd  = 1'b0;
    req_play  = 1'b0;

    if (state == WAIT_STOP) begin
      if (wait_cnt == '0) state_nxt = STOP;
      else                wait_nxt  = wait_cnt - 1'b1;
    end

    if (cmd_valid_in && cmd_in != CMD_NOP) begin
      if (!cmd_is_known(cmd_in) || state == WAIT_STOP) begin
        err_nxt[STATUS_CMD_ERR] = 1'b1;
      end else begin
        case (cmd_in)
          CMD_CLR: begin
            if (state == PLAY) begin
              err_nxt[STATUS_CLR_ERR] = 1'b1;
            end else begin
              clr_nxt   = 1'b1;
              err_nxt   = '0;
              state_nxt = WAIT_STOP;
              wait_nxt  = WAIT_LAST;
            end
          end
          CMD_CFG: begin
            if (state == PLAY) begin
              err_nxt[STATUS_CFG_ERR] = 1'b1;
            end else begin
              cfg_nxt   = 1'b1;
              state_nxt = WAIT_STOP;
              wait_nxt  = WAIT_LAST;
`ifdef AUDIOPORT_RATE_384K_EN
              rate_nxt = cfg_rate;
`else
              if (cfg_rate == RATE_384000) err_nxt[STATUS_CFG_ERR] = 1'b1;
              else                         rate_nxt = cfg_rate;
`endif
            end
          end
          CMD_START: begin
            if (state == STOP) begin
              state_nxt = PLAY;
              div_clear = 1'b1;
            end
          end
          CMD_STOP: begin
            if (state == PLAY) begin
              state_nxt = STOP;
              stop_cmd  = 1'b1;
              irq_nxt   = 1'b0;
              div_clear = 1'b1;
            end
          end
          CMD_LEVEL:  level_nxt = 1'b1;
          CMD_IRQACK: irq_ack   = 1'b1;
          default: ;
        endcase
      end
    end

    // A refill request arriving with IRQACK wins: irq stays set and neither side is an error.
    req_play = req_in && (state == PLAY) && !stop_cmd;
    if (irq_ack && !req_play) begin
      if (irq) irq_nxt = 1'b0;
      else     err_nxt[STATUS_IRQ_ERR] = 1'b1;
    end
    if (req_play) begin
      irq_nxt = 1'b1;
      if (irq && !irq_ack) err_nxt[STATUS_IRQ_ERR] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STOP;
      wait_cnt <= '0;
      rate     <= RATE_48000;
      err      <= '0;
      irq      <= 1'b0;
      clr      <= 1'b0;
      cfg      <= 1'b0;
      level    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rate     <= rate_nxt;
      err      <= err_nxt;
      irq      <= irq_nxt;
      clr      <= clr_nxt;
      cfg      <= cfg_nxt;
      level    <= level_nxt;
    end
  end

  audioport_tick_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_48000 (DIV_48000),
    .DIV_96000 (DIV_96000),
    .DIV_192000(DIV_192000),
    .DIV_384000(DIV_384000)
  ) u_tick_divider (
    .clk   (clk),
    .rst   (rst),
    .enable(state == PLAY),
    .clear (div_clear),
    .rate  (rate),
    .tick  (tick_out)
  );

  assign play_out   = (state == PLAY);
  assign busy_out   = (state == WAIT_STOP);
  assign clr_out    = clr;
  assign cfg_out    = cfg;
  assign level_out  = level;
  assign irq_out    = irq;
  assign status_out = {27'b0, err, play_out};

endmodule

// File: tb/tb_audioport_cmd_sequencer.sv
// Self-checking bench for audioport_cmd_sequencer: strobe/tick scoreboard plus direct status checks.
`timescale 1ns/1ps
module tb_audioport_cmd_sequencer;
  import audioport_pkg::*;

  localparam int P48  = 1127;
  localparam int P96  = 564;
  localparam int P384 = 141;
`ifdef AUDIOPORT_RATE_384K_EN
  localparam int          P_RATE3  = P384;
  localparam logic [31:0] ST_RATE3 = 32'h0;
`else
  localparam int          P_RATE3  = P48;
  localparam logic [31:0] ST_RATE3 = 32'h4;
`endif
  localparam int K_CLR = 0, K_CFG = 1, K_LEVEL = 2, K_TICK = 3, K_NONE = -1;

  logic clk = 1'b0;
  logic rst, cmd_valid_in, req_in;
  logic [31:0] cmd_in, cfg_in, status_out;
  logic play_out, clr_out, cfg_out, level_out, irq_out, busy_out, tick_out;

  always #5 clk = ~clk;

  audioport_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid_in(cmd_valid_in), .cfg_in(cfg_in),
    .req_in(req_in), .play_out(play_out), .clr_out(clr_out), .cfg_out(cfg_out),
    .level_out(level_out), .irq_out(irq_out), .busy_out(busy_out), .tick_out(tick_out),
    .status_out(status_out)
  );

  typedef struct { int kind; int cyc; } exp_t;
  exp_t exp_q[$];
  int edge_cnt = 0;
  int n_checks = 0;
  int n_pass   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  task automatic push_exp(input int kind, input int cyc);
    exp_t e;
    int i;
    e.kind = kind;
    e.cyc  = cyc;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < cyc || (exp_q[i].cyc == cyc && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endtask

  // Strobes are checked against the scoreboard at every negedge.
  always @(negedge clk) begin
    logic [3:0] s;
    exp_t e;
    s = {tick_out, level_out, cfg_out, clr_out};
    while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
      e = exp_q.pop_front();
      check_eq("sb_missing", edge_cnt, e.cyc);
    end
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", {28'b0, s}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_kind", k, e.kind);
          check_eq("sb_cycle", edge_cnt, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [31:0] c, input int kind);
    if (kind != K_NONE) push_exp(kind, edge_cnt + 1);
    cmd_in       = c;
    cmd_valid_in = 1'b1;
    @(negedge clk);
    cmd_valid_in = 1'b0;
    cmd_in       = '0;
  endtask

  task automatic pulse_req();
    req_in = 1'b1;
    @(negedge clk);
    req_in = 1'b0;
  endtask

  task automatic push_ticks(input int period, input int n);
    int base;
    base = edge_cnt + 1;
    for (int k = 1; k <= n; k++) push_exp(K_TICK, base + k * period);
  endtask

  task automatic wait_busy(input int exp_len);
    int n;
    n = 0;
    while (busy_out && n < 60) begin
      n++;
      @(negedge clk);
    end
    check_eq("busy_len", n, exp_len);
  endtask

  task automatic wait_until(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {25'b0, play_out, clr_out, cfg_out, level_out, irq_out, busy_out, tick_out}, 32'h0);
    check_eq({tag, "_status"}, status_out, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_stop;
    rst = 1'b1; cmd_in = '0; cmd_valid_in = 1'b0; cfg_in = '0; req_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // CFG to 96 kHz: strobe, 24 busy cycles, then START is accepted at once.
    cfg_in = 32'h1;
    send(CMD_CFG, K_CFG);
    check_eq("cfg_busy", busy_out, 1'b1);
    wait_busy(24);
    check_eq("cfg_status", status_out, 32'h0);
    push_ticks(P96, 3);
    t_stop = edge_cnt + 1 + 3 * P96 + 10;
    send(CMD_START, K_NONE);
    check_eq("start_play", play_out, 1'b1);
    check_eq("start_status", status_out, 32'h1);

    // Interrupt handling while playing.
    pulse_req();
    check_eq("irq_set", irq_out, 1'b1);
    req_in = 1'b1;
    send(CMD_IRQACK, K_NONE);
    req_in = 1'b0;
    check_eq("ack_req_irq", irq_out, 1'b1);
    check_eq("ack_req_status", status_out, 32'h1);
    send(CMD_IRQACK, K_NONE);
    check_eq("ack_clears", irq_out, 1'b0);
    pulse_req();
    repeat (9) @(negedge clk);
    pulse_req();
    check_eq("overrun_irq", irq_out, 1'b1);
    check_eq("overrun_status", status_out, 32'h9);

    // Commands illegal or no-op in PLAY.
    send(CMD_CLR, K_NONE);
    check_eq("clr_in_play", status_out, 32'hB);
    send(CMD_CFG, K_NONE);
    check_eq("cfg_in_play", status_out, 32'hF);
    send(CMD_LEVEL, K_LEVEL);
    send(CMD_START, K_NONE);
    check_eq("start_in_play", play_out, 1'b1);

    wait_until(t_stop);
    send(CMD_STOP, K_NONE);
    check_eq("stop_play", play_out, 1'b0);
    check_eq("stop_irq", irq_out, 1'b0);
    check_eq("stop_status", status_out, 32'hE);
    send(CMD_CLR, K_CLR);
    check_eq("clr_clears", status_out, 32'h0);
    wait_busy(24);

    // Invalid command, then commands during the wait-state window.
    send(32'h3, K_NONE);
    check_eq("bad_cmd", status_out, 32'h10);
    send(CMD_CLR, K_CLR);
    check_eq("clr_clears2", status_out, 32'h0);
    wait_busy(24);
    cfg_in = 32'h0;
    send(CMD_CFG, K_CFG);
    @(negedge clk);
    send(CMD_NOP, K_NONE);
    check_eq("nop_in_wait", status_out, 32'h0);
    repeat (2) @(negedge clk);
    send(CMD_LEVEL, K_NONE);
    check_eq("level_in_wait", status_out, 32'h10);
    wait_busy(19);

    // Rate code 3.
    send(CMD_CLR, K_CLR);
    wait_busy(24);
    cfg_in = 32'h3;
    send(CMD_CFG, K_CFG);
    check_eq("rate3_status", status_out, ST_RATE3);
    wait_busy(24);
    push_ticks(P_RATE3, 3);
    t_stop = edge_cnt + 1 + 3 * P_RATE3 + 10;
    send(CMD_START, K_NONE);
    wait_until(t_stop);
    send(CMD_STOP, K_NONE);
    check_eq("rate3_stop", play_out, 1'b0);

    // Reset during WAIT_STOP, reset with a command in flight, reset during PLAY.
    send(CMD_CLR, K_CLR);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_wait");
    rst = 1'b1; cmd_in = CMD_CLR; cmd_valid_in = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid_in = 1'b0; cmd_in = '0;
    check_zero("rst_inflight");
    cfg_in = 32'h1;
    send(CMD_CFG, K_CFG);
    wait_busy(24);
    send(CMD_START, K_NONE);
    pulse_req();
    check_eq("play_irq", irq_out, 1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_play");
    push_ticks(P48, 2);
    t_stop = edge_cnt + 1 + 2 * P48 + 10;
    send(CMD_START, K_NONE);
    check_eq("restart_play", play_out, 1'b1);
    wait_until(t_stop);
    send(CMD_STOP, K_NONE);

    repeat (5) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
